shift_reg_univ: RTL

- Parametrised universal shift register; successor to the fixed 8-bit SIPO shifter.
- Supports hold, shift right, shift left and parallel load.
- Counts shifted bits and pulses frame_done once per WIDTH-bit frame.
- Sits between a bit-serial source/sink (button-stepped or UART-style) and parallel byte/word consumers.

---
 rtl/shreg_pkg.sv | 23 ++
 rtl/shreg_frame_cnt.sv | 43 ++++
 rtl/shift_reg_univ.sv | 75 +++++++
 3 files changed

// File: rtl/shreg_pkg.sv
//------------------------------------------------------------------------------
// Module : shreg_pkg
// Brief  : Shared types and helpers for the universal shift register.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_SHR  = 2'd1,
    MODE_SHL  = 2'd2,
    MODE_LOAD = 2'd3
  } shreg_mode_t;

  function automatic int shreg_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shreg_frame_cnt.sv
//------------------------------------------------------------------------------
// Module : shreg_frame_cnt
// Brief  : Counts shift strobes modulo WIDTH and pulses frame_done on wrap.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shreg_frame_cnt
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            restart,
  input  logic                            shift,
  output logic [shreg_cnt_w(WIDTH)-1:0]   bit_cnt,
  output logic                            frame_done
);

  localparam int CW = shreg_cnt_w(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  always_ff @(posedge clk) begin
    if (!reset_n || restart) begin
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else if (shift) begin
      if (bit_cnt == C_LAST) begin
        bit_cnt    <= '0;
        frame_done <= 1'b1;
      end else begin
        bit_cnt    <= bit_cnt + 1'b1;
        frame_done <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_reg_univ.sv
//------------------------------------------------------------------------------
// Module : shift_reg_univ
// Brief  : Parametrised universal shift register (hold/SHR/SHL/load) with
//          frame counter. Define SHREG_PARITY_EN to add the parity_out port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_reg_univ
  import shreg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic                          clr,
  input  shreg_mode_t                   mode,
  input  logic                          serial_in,
  input  logic [WIDTH-1:0]              load_data,
  output logic [WIDTH-1:0]              parallel_out,
  output logic                          serial_out,
  output logic [shreg_cnt_w(WIDTH)-1:0] bit_cnt,
  output logic                          frame_done
`ifdef SHREG_PARITY_EN
  ,
  output logic                          parity_out
`endif
);

  logic w_shift;
  logic w_restart;

  assign w_shift   = en && ((mode == MODE_SHR) || (mode == MODE_SHL));
  assign w_restart = clr || (en && (mode == MODE_LOAD));

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      parallel_out <= RESET_VAL;
      serial_out   <= 1'b0;
    end else if (en) begin
      case (mode)
        MODE_SHR: begin
          parallel_out <= {serial_in, parallel_out[WIDTH-1:1]};
          serial_out   <= parallel_out[0];
        end
        MODE_SHL: begin
          parallel_out <= {parallel_out[WIDTH-2:0], serial_in};
          serial_out   <= parallel_out[WIDTH-1];
        end
        MODE_LOAD: parallel_out <= load_data;
        default: ;
      endcase
    end
  end

  shreg_frame_cnt #(
    .WIDTH(WIDTH)
  ) u_frame_cnt (
    .clk       (clk),
    .reset_n   (reset_n),
    .restart   (w_restart),
    .shift     (w_shift),
    .bit_cnt   (bit_cnt),
    .frame_done(frame_done)
  );

`ifdef SHREG_PARITY_EN
  assign parity_out = ^parallel_out;
`endif

endmodule

`default_nettype wire
